// File: rtl/debug_mem_writer_if.sv
// Write-side bus of the debug poke unit: memory req/ack handshake plus
// register-file / PSW write strobes.
interface debug_mem_writer_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);
  logic              mem_req;
  logic              mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              reg_we;
  logic              psw_we;
  logic [2:0]        reg_idx;
  logic [DATA_W-1:0] reg_wdata;

  modport master (
    output mem_req, mem_addr, mem_wdata, reg_we, psw_we, reg_idx, reg_wdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req, mem_addr, mem_wdata, reg_we, psw_we, reg_idx, reg_wdata,
    output mem_ack
  );
endinterface

// File: rtl/debug_mem_writer.sv
// Board-level debug poke unit: user keys an address then data on SW and the
// block writes main memory (req/ack) or the register file / PSW (1-cycle strobe).
// Optional feature macro: ADDR_AUTOINC_EN (enter in S_DONE bumps the address
// and returns to S_DATA for streaming pokes).
module debug_mem_writer #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                 Clock,
  input  logic                 Reset_n,
  input  logic [15:0]          SW,
  input  logic                 key_enter,
  input  logic                 key_cancel,
  input  logic [1:0]           mem_mode,
  debug_mem_writer_if.master   bus,
  output logic [15:0]          disp_value,
  output logic [5:0]           LEDG,
  output logic [15:0]          LEDR
);

  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_REG = 2'b10;

  typedef enum logic [2:0] {
    S_ADDR,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        tgt_q, tgt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;
  logic              mem_req_q, mem_req_d;
  logic              reg_we_q, reg_we_d;
  logic              psw_we_q, psw_we_d;
  logic [5:0]        ledg_q, ledg_d;
  logic [15:0]       disp_q, disp_d;
  // [0],[1] synchroniser stages, [2] previous synced level for edge detect
  logic [2:0]        ent_sync_q, ent_sync_d;
  logic [2:0]        can_sync_q, can_sync_d;
  logic              enter_p, cancel_p;

  // Key synchronisers and falling-edge press pulses; cancel masks enter
  always_comb begin
    ent_sync_d = {ent_sync_q[1:0], key_enter};
    can_sync_d = {can_sync_q[1:0], key_cancel};
    cancel_p   = can_sync_q[2] & ~can_sync_q[1];
    enter_p    = ent_sync_q[2] & ~ent_sync_q[1] & ~cancel_p;
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tgt_d     = tgt_q;
    timer_d   = timer_q;
    mem_req_d = 1'b0;
    reg_we_d  = 1'b0;
    psw_we_d  = 1'b0;

    case (state_q)
      S_ADDR: begin
        if (enter_p) begin
          addr_d = ADDR_W'(SW);
          tgt_d  = mem_mode;
          if (mem_mode == MODE_MEM) begin
            state_d = S_DATA;
          end else if (mem_mode == MODE_REG && SW[3:0] <= 4'd8) begin
            state_d = S_DATA;
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_DATA: begin
        if (cancel_p) begin
          state_d = S_ADDR;
        end else if (enter_p) begin
          data_d  = DATA_W'(SW);
          timer_d = '0;
          state_d = S_WRITE;
          // Strobe/request launch on the same edge as entering S_WRITE
          if (tgt_q == MODE_REG) begin
            reg_we_d = ~addr_q[3];
            psw_we_d = addr_q[3];
          end else begin
            mem_req_d = 1'b1;
          end
        end
      end
      S_WRITE: begin
        if (tgt_q == MODE_REG) begin
          state_d = S_DONE;
        end else if (bus.mem_ack) begin
          state_d = S_DONE;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          state_d = S_ERR;
        end else begin
          mem_req_d = 1'b1;
          timer_d   = timer_q + TMR_W'(1);
        end
      end
      S_DONE: begin
        if (cancel_p) begin
          state_d = S_ADDR;
        end else if (enter_p) begin
`ifdef ADDR_AUTOINC_EN
          // Register targets cycle through R0..R7 and PSW (index 8)
          if (tgt_q == MODE_REG && addr_q[3:0] == 4'd8) begin
            addr_d = {addr_q[ADDR_W-1:4], 4'd0};
          end else begin
            addr_d = addr_q + ADDR_W'(1);
          end
          state_d = S_DATA;
`else
          state_d = S_ADDR;
`endif
        end
      end
      S_ERR: begin
        if (cancel_p) begin
          state_d = S_ADDR;
        end
      end
      default: state_d = S_ADDR;
    endcase

    ledg_d = {tgt_d == MODE_REG, state_d == S_ERR, state_d == S_DONE,
              state_d == S_WRITE, state_d == S_DATA, state_d == S_ADDR};
    disp_d = (state_d == S_ADDR || state_d == S_DATA) ? SW : 16'(data_d);
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      state_q    <= S_ADDR;
      addr_q     <= '0;
      data_q     <= '0;
      tgt_q      <= '0;
      timer_q    <= '0;
      mem_req_q  <= 1'b0;
      reg_we_q   <= 1'b0;
      psw_we_q   <= 1'b0;
      ledg_q     <= 6'b000001;
      disp_q     <= '0;
      ent_sync_q <= 3'b111;
      can_sync_q <= 3'b111;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      tgt_q      <= tgt_d;
      timer_q    <= timer_d;
      mem_req_q  <= mem_req_d;
      reg_we_q   <= reg_we_d;
      psw_we_q   <= psw_we_d;
      ledg_q     <= ledg_d;
      disp_q     <= disp_d;
      ent_sync_q <= ent_sync_d;
      can_sync_q <= can_sync_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = data_q;
  assign bus.reg_we    = reg_we_q;
  assign bus.psw_we    = psw_we_q;
  assign bus.reg_idx   = addr_q[2:0];
  assign bus.reg_wdata = data_q;
  assign disp_value    = disp_q;
  assign LEDG          = ledg_q;
  assign LEDR          = 16'(addr_q);

endmodule

// File: tb/tb_debug_mem_writer.sv
// Bench for debug_mem_writer: vector table, random pokes against a
// rule-level model, and hand sequences for reset / key corner cases.
module tb_debug_mem_writer;

  localparam int K_MEM = 0;
  localparam int K_REG = 1;
  localparam int K_PSW = 2;
  localparam int K_ERR = 3;
  localparam int TIMEOUT = 255;

  logic        Clock;
  logic        Reset_n;
  logic [15:0] SW;
  logic        key_enter;
  logic        key_cancel;
  logic [1:0]  mem_mode;
  logic [15:0] disp_value;
  logic [5:0]  LEDG;
  logic [15:0] LEDR;

  debug_mem_writer_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  debug_mem_writer #(.ADDR_W(16), .DATA_W(16), .ACK_TIMEOUT(TIMEOUT)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .SW         (SW),
    .key_enter  (key_enter),
    .key_cancel (key_cancel),
    .mem_mode   (mem_mode),
    .bus        (bus),
    .disp_value (disp_value),
    .LEDG       (LEDG),
    .LEDR       (LEDR)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  // Written by the main process only, read by the monitor
  int          ack_delay_v = 0;
  logic [15:0] exp_addr_m = '0;
  logic [15:0] exp_data_m = '0;
  logic        tgt_reg_m = 1'b0;

  // Written by the monitor only
  int          req_cycles = 0;
  int          req_run = 0;
  int          reg_cnt = 0;
  int          psw_cnt = 0;
  int          stab_bad = 0;
  logic [2:0]  last_idx = '0;
  logic [15:0] last_wd = '0;

  // Bus monitor and acking memory model
  always @(negedge Clock) begin
    if (bus.mem_req === 1'b1) begin
      req_cycles = req_cycles + 1;
      req_run    = req_run + 1;
      if (bus.mem_addr !== exp_addr_m || bus.mem_wdata !== exp_data_m) stab_bad = stab_bad + 1;
      bus.mem_ack = (ack_delay_v != 0 && req_run == ack_delay_v);
    end else begin
      req_run     = 0;
      bus.mem_ack = 1'b0;
    end
    if (bus.reg_we === 1'b1) begin
      reg_cnt  = reg_cnt + 1;
      last_idx = bus.reg_idx;
      last_wd  = bus.reg_wdata;
      if (bus.psw_we === 1'b1) stab_bad = stab_bad + 1;
    end
    if (bus.psw_we === 1'b1) begin
      psw_cnt = psw_cnt + 1;
      last_wd = bus.reg_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic press_key(input bit ent, input bit can, input int hold);
    key_enter  = ent ? 1'b0 : 1'b1;
    key_cancel = can ? 1'b0 : 1'b1;
    repeat (hold) @(negedge Clock);
    key_enter  = 1'b1;
    key_cancel = 1'b1;
    repeat (4) @(negedge Clock);
  endtask

  task automatic to_addr();
    press_key(1'b0, 1'b1, 4);
    chk("cancel_to_addr", 32'(LEDG), 32'({tgt_reg_m, 5'b00001}));
  endtask

  // One full poke: address, data, wait for completion, compare outcome
  task automatic run_txn(input logic [1:0] mode, input logic [15:0] addr,
                         input logic [15:0] data, input int ack, input int kind,
                         input int exp_req, input logic [5:0] exp_ledg);
    int r0, rw0, pw0, sb0, n;
    mem_mode = mode;
    SW       = addr;
    press_key(1'b1, 1'b0, 4);
    tgt_reg_m = (mode == 2'b10);
    if (kind == K_ERR) begin
      chk("addr_err_ledg", 32'(LEDG), 32'(exp_ledg));
      return;
    end
    chk("data_ledg", 32'(LEDG), 32'({tgt_reg_m, 5'b00010}));
    exp_addr_m  = addr;
    exp_data_m  = data;
    ack_delay_v = ack;
    r0 = req_cycles; rw0 = reg_cnt; pw0 = psw_cnt; sb0 = stab_bad;
    SW = data;
    press_key(1'b1, 1'b0, 4);
    n = 0;
    while (!(LEDG[3] || LEDG[4]) && n < 400) begin
      @(negedge Clock);
      n = n + 1;
    end
    chk("write_complete_bound", 32'(n < 400), 32'd1);
    chk("final_ledg", 32'(LEDG), 32'(exp_ledg));
    chk("req_cycles", 32'(req_cycles - r0), 32'(exp_req));
    chk("reg_we_pulses", 32'(reg_cnt - rw0), 32'(kind == K_REG));
    chk("psw_we_pulses", 32'(psw_cnt - pw0), 32'(kind == K_PSW));
    chk("bus_stable", 32'(stab_bad - sb0), 32'd0);
    chk("ledr_addr", 32'(LEDR), 32'(addr));
    chk("mem_addr", 32'(bus.mem_addr), 32'(addr));
    chk("wdata", 32'({bus.mem_wdata, bus.reg_wdata}), {data, data});
    chk("disp_data", 32'(disp_value), 32'(data));
    if (kind == K_REG) chk("reg_idx", 32'(last_idx), 32'(addr[2:0]));
    if (kind == K_REG || kind == K_PSW) chk("reg_wdata_at_strobe", 32'(last_wd), 32'(data));
  endtask

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] addr;
    logic [15:0] data;
    int          ack;
    int          kind;
    int          exp_req;
    logic [5:0]  exp_ledg;
  } vec_t;

  vec_t vecs[11];

  initial begin
    int          r0, rw0, pw0;
    logic [1:0]  m;
    logic [15:0] a, d;
    int          ak, kd, er;
    logic [5:0]  el;
    logic [3:0]  nib;

    vecs[0]  = '{2'b01, 16'h0040, 16'hBEEF, 3, K_MEM, 3,       6'b001000};
    vecs[1]  = '{2'b10, 16'h0005, 16'h1234, 0, K_REG, 0,       6'b101000};
    vecs[2]  = '{2'b10, 16'h0008, 16'hCAFE, 0, K_PSW, 0,       6'b101000};
    vecs[3]  = '{2'b10, 16'h000A, 16'h0000, 0, K_ERR, 0,       6'b110000};
    vecs[4]  = '{2'b01, 16'h1234, 16'h5555, 1, K_MEM, 1,       6'b001000};
    vecs[5]  = '{2'b01, 16'h0100, 16'h0F0F, 0, K_MEM, TIMEOUT, 6'b010000};
    vecs[6]  = '{2'b00, 16'h0001, 16'h0000, 0, K_ERR, 0,       6'b010000};
    vecs[7]  = '{2'b11, 16'h0002, 16'h0000, 0, K_ERR, 0,       6'b010000};
    vecs[8]  = '{2'b10, 16'h00F7, 16'h7777, 0, K_REG, 0,       6'b101000};
    vecs[9]  = '{2'b10, 16'h0019, 16'h0000, 0, K_ERR, 0,       6'b110000};
    vecs[10] = '{2'b10, 16'h0000, 16'hA5A5, 0, K_REG, 0,       6'b101000};

    Reset_n = 1'b0; SW = '0; key_enter = 1'b1; key_cancel = 1'b1; mem_mode = 2'b00;
    repeat (3) @(negedge Clock);
    chk("rst_ledg", 32'(LEDG), 32'h01);
    chk("rst_ledr", 32'(LEDR), 32'h0);
    chk("rst_strobes", 32'({bus.mem_req, bus.reg_we, bus.psw_we}), 32'h0);
    Reset_n = 1'b1;
    SW = 16'h5A5A;
    repeat (3) @(negedge Clock);
    chk("disp_live_sw", 32'(disp_value), 32'h5A5A);

    // Directed vector table
    for (int i = 0; i < 11; i++) begin
      run_txn(vecs[i].mode, vecs[i].addr, vecs[i].data, vecs[i].ack,
              vecs[i].kind, vecs[i].exp_req, vecs[i].exp_ledg);
      to_addr();
    end

    // Randomised pokes against the rule-level model
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 5))
        0, 1: m = 2'b01;
        2, 3: m = 2'b10;
        4:    m = 2'b00;
        default: m = 2'b11;
      endcase
      a = 16'($urandom);
      if (m == 2'b10 && $urandom_range(0, 1) == 1) a[3:0] = 4'($urandom_range(0, 8));
      d  = 16'($urandom);
      ak = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 6));
      nib = a[3:0];
      if (m == 2'b01) begin
        kd = K_MEM;
        er = (ak == 0) ? TIMEOUT : ak;
        el = (ak == 0) ? 6'b010000 : 6'b001000;
      end else if (m == 2'b10) begin
        er = 0;
        if (nib < 8)       begin kd = K_REG; el = 6'b101000; end
        else if (nib == 8) begin kd = K_PSW; el = 6'b101000; end
        else               begin kd = K_ERR; el = 6'b110000; end
      end else begin
        kd = K_ERR; er = 0; el = 6'b010000;
      end
      run_txn(m, a, d, ak, kd, er, el);
      to_addr();
    end

    // Cancel in S_ADDR is ignored
    press_key(1'b0, 1'b1, 4);
    chk("cancel_ignored_in_addr", 32'(LEDG), 32'({tgt_reg_m, 5'b00001}));

    // Enter held for 100 cycles gives exactly one transition
    r0 = req_cycles;
    mem_mode = 2'b01; SW = 16'h0777;
    press_key(1'b1, 1'b0, 100);
    tgt_reg_m = 1'b0;
    chk("hold_one_step", 32'(LEDG), 32'b000010);
    chk("hold_no_req", 32'(req_cycles - r0), 32'd0);
    SW = 16'h1357;
    repeat (2) @(negedge Clock);
    chk("disp_live_in_data", 32'(disp_value), 32'h1357);

    // Enter and cancel together in S_DATA: cancel wins, address kept
    press_key(1'b1, 1'b1, 4);
    chk("both_keys_cancel", 32'(LEDG), 32'b000001);
    chk("addr_kept", 32'(LEDR), 32'h0777);
    chk("both_no_req", 32'(req_cycles - r0), 32'd0);

    // Enter ignored in S_ERR
    mem_mode = 2'b00;
    press_key(1'b1, 1'b0, 4);
    press_key(1'b1, 1'b0, 4);
    chk("enter_ignored_in_err", 32'(LEDG), 32'b010000);
    to_addr();

`ifdef ADDR_AUTOINC_EN
    // Address auto-increment wraps 0xFFFF to 0x0000 and streams into S_DATA
    run_txn(2'b01, 16'hFFFF, 16'h1111, 2, K_MEM, 2, 6'b001000);
    press_key(1'b1, 1'b0, 4);
    chk("autoinc_to_data", 32'(LEDG), 32'b000010);
    chk("autoinc_wrap", 32'(LEDR), 32'h0000);
    press_key(1'b0, 1'b1, 4);
    chk("autoinc_cancel", 32'(LEDG), 32'b000001);
`endif

    // Reset in the middle of a memory write
    mem_mode = 2'b01; SW = 16'h0321;
    press_key(1'b1, 1'b0, 4);
    exp_addr_m = 16'h0321; exp_data_m = 16'h4242; ack_delay_v = 0;
    SW = 16'h4242;
    press_key(1'b1, 1'b0, 4);
    chk("req_before_reset", 32'(bus.mem_req), 32'd1);
    rw0 = reg_cnt; pw0 = psw_cnt;
    Reset_n = 1'b0;
    @(negedge Clock);
    chk("reset_drops_req", 32'(bus.mem_req), 32'd0);
    @(negedge Clock);
    chk("reset_ledg", 32'(LEDG), 32'h01);
    chk("reset_ledr", 32'(LEDR), 32'h0);
    chk("reset_no_strobe", 32'((reg_cnt - rw0) + (psw_cnt - pw0)), 32'd0);
    Reset_n = 1'b1;
    tgt_reg_m = 1'b0;
    repeat (3) @(negedge Clock);
    chk("post_reset_idle", 32'({bus.mem_req, bus.reg_we, bus.psw_we}), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
